// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: a thermometer LED bar sweeping between configurable bounds, with flick kickback.
// Optional: define BOUND_FLASHER_AUTO_REPEAT_EN to restart the sweep forever instead of returning to INIT.
module bound_flasher_param #(
  parameter int N_LED = 16,
  parameter int B_LO  = 5,
  parameter int B_MID = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  input  logic             step_en,
  output logic [N_LED-1:0] LEDs,
  output logic             busy,
  output logic [2:0]       state_o
);

  localparam int CW = $clog2(N_LED + 1);

  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_MAX  = CW'(N_LED);
  localparam logic [CW-1:0] C_LO   = CW'(B_LO);
  localparam logic [CW-1:0] C_MID  = CW'(B_MID);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_UP1  = 3'd1,
    ST_DN1  = 3'd2,
    ST_UP2  = 3'd3,
    ST_DN2  = 3'd4,
    ST_UP3  = 3'd5,
    ST_DN3  = 3'd6,
    ST_KB0  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] inc_s, dec_s;
  logic          busy_q;

  assign inc_s = cnt_q + C_ONE;
  assign dec_s = cnt_q - C_ONE;

  // Next-state/count logic; an up state already at the top or a down state at 0 is treated as corrupt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cnt_q > C_MAX) begin
      state_d = ST_INIT;
      cnt_d   = C_ZERO;
    end else if (!step_en) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (flick) begin
            state_d = ST_UP1;
            cnt_d   = C_ONE;
          end else begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end
        end
        ST_UP1: begin
          if (cnt_q == C_MAX) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = inc_s;
            if (inc_s == C_MAX) begin
              state_d = ST_DN1;
            end else if (flick && ((inc_s == C_LO) || (inc_s == C_MID))) begin
              state_d = ST_KB0;
            end else begin
              state_d = ST_UP1;
            end
          end
        end
        ST_DN1: begin
          if (cnt_q == C_ZERO) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = dec_s;
            if (dec_s == C_LO) begin
              state_d = ST_UP2;
            end else begin
              state_d = ST_DN1;
            end
          end
        end
        ST_UP2: begin
          if (cnt_q == C_MAX) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = inc_s;
            if (inc_s == C_MID) begin
              state_d = flick ? ST_DN1 : ST_DN2;
            end else begin
              state_d = ST_UP2;
            end
          end
        end
        ST_DN2: begin
          if (cnt_q == C_ZERO) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = dec_s;
            if (dec_s == C_ZERO) begin
              state_d = ST_UP3;
            end else begin
              state_d = ST_DN2;
            end
          end
        end
        ST_UP3: begin
          if (cnt_q == C_MAX) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = inc_s;
            if (inc_s == C_LO) begin
              state_d = ST_DN3;
            end else begin
              state_d = ST_UP3;
            end
          end
        end
        ST_DN3: begin
          if (cnt_q == C_ZERO) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = dec_s;
            if (dec_s == C_ZERO) begin
`ifdef BOUND_FLASHER_AUTO_REPEAT_EN
              state_d = ST_UP1;
`else
              state_d = ST_INIT;
`endif
            end else begin
              state_d = ST_DN3;
            end
          end
        end
        ST_KB0: begin
          if (cnt_q == C_ZERO) begin
            state_d = ST_INIT;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = dec_s;
            if (dec_s == C_ZERO) begin
              state_d = ST_UP1;
            end else begin
              state_d = ST_KB0;
            end
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = C_ZERO;
        end
      endcase
    end
  end

  // State, count and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= C_ZERO;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_INIT);
    end
  end

  // Thermometer decode of the registered count.
  always_comb begin
    LEDs = {N_LED{1'b0}};
    for (int i = 0; i < N_LED; i++) begin
      LEDs[i] = (cnt_q > i[CW-1:0]);
    end
  end

  assign busy    = busy_q;
  assign state_o = state_q;

endmodule
